seven_seg_decoder: RTL and testbench
====================================

// Module: seven_seg_decoder
// PURPOSE
//  Receive-side companion to the hex->7-segment encoder. Samples seven segment
//  lines (A..G) driven by an external or looped-back display driver and
//  qualifies each pattern as stable. Decodes it back to a 4-bit hex digit and
//  presents it on a valid/ready handshake. Unrecognised patterns raise an
//  error strobe; a digit not collected in time raises an overrun strobe.
// PARAMETERS
//  STABLE_CYCLES  4  synchronised clocks a pattern must hold before acceptance (>=1)
// PORTS
//  CLK          in   1  sole clock, all logic on posedge
//  RST          in   1  synchronous, active-high reset
//  Segment1_A   in   1  segment A (pattern bit 6)
//  Segment1_B   in   1  segment B (bit 5)
//  Segment1_C   in   1  segment C (bit 4)
//  Segment1_D   in   1  segment D (bit 3)
//  Segment1_E   in   1  segment E (bit 2)
//  Segment1_F   in   1  segment F (bit 1)
//  Segment1_G   in   1  segment G (bit 0)
//  Digit        out  4  decoded hex value, held while Digit_Valid=1
//  Digit_Valid  out  1  decoded digit pending
//  Digit_Ready  in   1  consumer accepts; transfer when Valid & Ready
//  Error        out  1  1-cycle strobe: accepted pattern is not a legal code
//  Overrun      out  1  1-cycle strobe: pending digit overwritten
// BEHAVIOUR
//  - Reset: Digit=0, Digit_Valid=0, Error=0, Overrun=0; sync flops, stability
//    counter and last-accepted pattern cleared to 7'h00 (blank).
//  - Input path: 2-flop synchroniser per segment -> 7-bit pattern P.
//  - Stability: counter clears when P differs from the previous cycle's P,
//    else increments, saturating at STABLE_CYCLES. Acceptance fires once, in
//    the cycle the counter reaches STABLE_CYCLES, only if P != last-accepted.
//  - Latency: the posedge that first samples a new stable pattern is edge 0.
//    Digit_Valid/Error is high after edge 2+STABLE_CYCLES.
//  - Decode table (P -> Digit): 7E:0 30:1 6D:2 79:3 33:4 5B:5 5F:6 70:7 7F:8
//    7B:9 77:A 1F:B 4E:C 3D:D 4F:E 47:F.
//  - P=7'h00 (blank) accepted: updates last-accepted, no output change.
//    The same digit after a blank is therefore re-emitted.
//  - Illegal non-blank P accepted: Error pulses 1 cycle; Digit and
//    Digit_Valid are unchanged; last-accepted is updated (no repeat error).
//  - Handshake: Digit_Valid stays high, Digit stable, until Valid&Ready.
//    Ready while Valid=0 is ignored.
//  - Legal acceptance while Valid=1 and Ready=0: Digit is overwritten,
//    Valid stays 1, Overrun pulses 1 cycle.
//  - Legal acceptance in the same cycle as Valid&Ready: old digit consumed,
//    new digit loaded, Valid stays 1, no Overrun.
//  - Mid-transition glitches shorter than STABLE_CYCLES: never accepted.
//  - RST asserted mid-operation clears everything on the next edge. A pending
//    digit is lost, and no Error/Overrun is generated by the reset.
//  - States: IDLE (no pending digit), PEND (Digit_Valid=1).
//    IDLE->PEND on legal acceptance. PEND->IDLE on Valid&Ready without a
//    simultaneous acceptance. PEND->PEND otherwise.
// CONFIGURATION
//  SEG_ACTIVE_LOW_EN defined: segment inputs are inverted before the
//    synchroniser, for boards that drive segments low = lit.
//    Sync flops reset to 0 after inversion, so reset still reads as blank.
//  Not defined: segment inputs are active-high, used as-is.
// TESTING
//  1. Reset, hold 7'h6D with Ready=0 -> Valid=1, Digit=2 after edge 2+4.
//     Holds indefinitely.
//  2. Pending Digit=2, pulse Ready 1 cycle -> Valid=0 next cycle.
//     Re-present 6D without a blank -> no new Valid.
//  3. Present 7'h01 for 10 cycles -> single Error pulse, Valid unchanged.
//  4. Present 7E then 30, each 8 cycles, Ready=0 -> Digit=1, Valid=1,
//     one Overrun pulse.
//  5. Toggle 7E<->30 every 2 cycles (STABLE_CYCLES=4) -> no acceptance,
//     no Valid, no Error.
//  6. Assert RST while Valid=1 and 47 is stable -> all outputs 0.
//     After RST drops, 47 is re-accepted: Digit=F.

Source files
------------

// File: rtl/seven_seg_decoder.sv
// Seven-segment pattern receiver: synchronises segment lines, qualifies a
// stable pattern, decodes it to a hex digit and offers it on valid/ready.
//
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   Segment1_A..G          segment lines (A = pattern bit 6 .. G = bit 0)
//   Digit, Digit_Valid     decoded digit and pending flag
//   Digit_Ready            consumer accept (transfer on Valid & Ready)
//   Error                  1-cycle strobe: accepted pattern is not a hex code
//   Overrun                1-cycle strobe: pending digit was overwritten
//
// Build option: define SEG_ACTIVE_LOW_EN for boards that drive a lit
// segment low; the lines are then inverted ahead of the synchroniser.
module seven_seg_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Segment1_A,
  input  logic       Segment1_B,
  input  logic       Segment1_C,
  input  logic       Segment1_D,
  input  logic       Segment1_E,
  input  logic       Segment1_F,
  input  logic       Segment1_G,
  output logic [3:0] Digit,
  output logic       Digit_Valid,
  input  logic       Digit_Ready,
  output logic       Error,
  output logic       Overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(STABLE_CYCLES);
  // The counter reaches STABLE_CYCLES on the edge it leaves this value.
  localparam cnt_t CNT_TGT = cnt_t'(STABLE_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_PEND
  } state_t;

  logic [6:0] seg_raw;
  logic [6:0] seg_in;

  assign seg_raw = {Segment1_A, Segment1_B, Segment1_C, Segment1_D,
                    Segment1_E, Segment1_F, Segment1_G};

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_in = ~seg_raw;
`else
  assign seg_in = seg_raw;
`endif

  logic [6:0] sync1_q, sync1_d;
  logic [6:0] sync2_q, sync2_d;
  logic [6:0] prev_q, prev_d;
  logic [6:0] last_q, last_d;
  cnt_t       cnt_q, cnt_d;
  state_t     state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic       err_q, err_d;
  logic       ovr_q, ovr_d;

  logic       same;
  logic       fresh;
  logic       xfer;
  logic       legal;
  logic [3:0] dec;

  // Returns {legal, digit}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b0;
    unique case (p)
      7'h7E:   r = {1'b1, 4'h0};
      7'h30:   r = {1'b1, 4'h1};
      7'h6D:   r = {1'b1, 4'h2};
      7'h79:   r = {1'b1, 4'h3};
      7'h33:   r = {1'b1, 4'h4};
      7'h5B:   r = {1'b1, 4'h5};
      7'h5F:   r = {1'b1, 4'h6};
      7'h70:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h7B:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h1F:   r = {1'b1, 4'hB};
      7'h4E:   r = {1'b1, 4'hC};
      7'h3D:   r = {1'b1, 4'hD};
      7'h4F:   r = {1'b1, 4'hE};
      7'h47:   r = {1'b1, 4'hF};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    sync1_d = seg_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    same    = (sync2_q == prev_q);
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + cnt_t'(1);
    end
    // One-shot: fires only on the transition into saturation.
    fresh = same && (cnt_q == CNT_TGT) && (sync2_q != last_q);
    {legal, dec} = decode(sync2_q);
    xfer    = (state_q == S_PEND) && Digit_Ready;

    state_d = state_q;
    digit_d = digit_q;
    last_d  = last_q;
    err_d   = 1'b0;
    ovr_d   = 1'b0;

    if (xfer) begin
      state_d = S_IDLE;
    end
    if (fresh) begin
      last_d = sync2_q;
      if (sync2_q != 7'h00) begin
        if (legal) begin
          digit_d = dec;
          state_d = S_PEND;
          ovr_d   = (state_q == S_PEND) && !Digit_Ready;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
      digit_q <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      digit_q <= digit_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Digit       = digit_q;
  assign Digit_Valid = (state_q == S_PEND);
  assign Error       = err_q;
  assign Overrun     = ovr_q;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Bench for seven_seg_decoder: directed scenarios plus random patterns,
// checked each cycle against a run-length reference model via a scoreboard.
module tb_seven_seg_decoder;

  localparam int S = 4;

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] pat = 7'h00;
  logic       ready = 1'b0;
  logic [6:0] seg;
  logic [3:0] digit;
  logic       valid;
  logic       err;
  logic       ovr;

  int checks = 0;
  int errors = 0;

  assign seg = pat ^ {7{INV}};

  always #5 clk = ~clk;

  seven_seg_decoder #(.STABLE_CYCLES(S)) dut (
    .CLK         (clk),
    .RST         (rst),
    .Segment1_A  (seg[6]),
    .Segment1_B  (seg[5]),
    .Segment1_C  (seg[4]),
    .Segment1_D  (seg[3]),
    .Segment1_E  (seg[2]),
    .Segment1_F  (seg[1]),
    .Segment1_G  (seg[0]),
    .Digit       (digit),
    .Digit_Valid (valid),
    .Digit_Ready (ready),
    .Error       (err),
    .Overrun     (ovr)
  );

  logic [6:0] codes [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic int code_idx(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (codes[i] == p) return i;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       e;
    logic       o;
  } exp_t;

  exp_t sb[$];

  // Reference model: pattern seen by the decoder lags the pins by two
  // edges; a pattern is taken when its run length first hits S+1.
  logic [6:0] m_s1, m_s2, run_val, last, p;
  int         run_len, idx;
  logic       m_v, m_e, m_o, xfer, busy;
  logic [3:0] m_d;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; run_val = 0; run_len = 1; last = 0;
      m_v = 0; m_d = 0; m_e = 0; m_o = 0;
    end else begin
      p = m_s2;
      xfer = m_v && ready;
      busy = m_v && !ready;
      m_e = 0;
      m_o = 0;
      if (p == run_val) run_len++;
      else begin
        run_val = p;
        run_len = 1;
      end
      if (xfer) m_v = 0;
      if (run_len == S + 1 && p != last) begin
        last = p;
        if (p != 0) begin
          idx = code_idx(p);
          if (idx >= 0) begin
            m_o = busy;
            m_v = 1;
            m_d = 4'(idx);
          end else begin
            m_e = 1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = pat;
    end
    sb.push_back('{v: m_v, d: m_d, e: m_e, o: m_o});
  end

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check("valid", 32'(valid), 32'(x.v));
      if (x.v) check("digit", 32'(digit), 32'(x.d));
      check("error", 32'(err), 32'(x.e));
      check("overrun", 32'(ovr), 32'(x.o));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hold;
    int sel;
    step(3);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    rst = 0;

    pat = 7'h6D;
    step(12);
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_digit", 32'(digit), 32'd2);
    step(10);

    ready = 1;
    step(1);
    ready = 0;
    step(1);
    check("t2_valid", 32'(valid), 32'd0);
    step(10);

    pat = 7'h01;
    step(10);
    pat = 7'h00;
    step(8);

    pat = 7'h7E;
    step(8);
    pat = 7'h30;
    step(8);
    check("t4_valid", 32'(valid), 32'd1);
    check("t4_digit", 32'(digit), 32'd1);
    ready = 1;
    step(1);
    ready = 0;

    for (int i = 0; i < 6; i++) begin
      pat = 7'h7E;
      step(2);
      pat = 7'h30;
      step(2);
    end
    pat = 7'h00;
    step(8);

    pat = 7'h47;
    step(10);
    rst = 1;
    step(2);
    check("t6_valid", 32'(valid), 32'd0);
    check("t6_digit", 32'(digit), 32'd0);
    rst = 0;
    step(10);
    check("t6_revalid", 32'(valid), 32'd1);
    check("t6_redigit", 32'(digit), 32'd15);
    ready = 1;
    step(1);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) pat = codes[$urandom_range(0, 15)];
      else if (sel < 7) pat = 7'h00;
      else pat = 7'($urandom);
      hold = $urandom_range(1, 9);
      for (int j = 0; j < hold; j++) begin
        ready = ($urandom_range(0, 3) == 0);
        step(1);
      end
    end
    ready = 0;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
